// File: rtl/generador_cubos.sv
`default_nettype none
// ---------------------------------------------------------------------------
// generador_cubos: LFSR-driven cube type source with valid/ready handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module generador_cubos #(
  parameter int         PERIODO_SPAWN = 60,
  parameter logic [7:0] SEMILLA       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilitar,
  input  logic       tick_frame,
  input  logic       cubo_listo,
  output logic [2:0] tipo_cubo,
  output logic       cubo_valido,
  output logic [7:0] cubos_generados
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEMILLA_EF  = (SEMILLA == 8'h00) ? 8'h01 : SEMILLA;
  localparam logic [7:0] ULTIMO_TICK = 8'(PERIODO_SPAWN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    SORTEO = 2'd2,
    OFERTA = 2'd3
  } estado_t;

  estado_t    estado, estado_sig;
  logic [7:0] lfsr, lfsr_sig;
  logic [7:0] frames, frames_sig;
  logic [7:0] generados_sig, generados_inc;
  logic [2:0] tipo_sig;
  logic       valido_sig;

  assign lfsr_sig      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign generados_inc = (cubos_generados == 8'hFF) ? 8'hFF : cubos_generados + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= IDLE;
      lfsr            <= SEMILLA_EF;
      frames          <= 8'd0;
      tipo_cubo       <= 3'd0;
      cubo_valido     <= 1'b0;
      cubos_generados <= 8'd0;
    end else begin
      estado          <= estado_sig;
      lfsr            <= lfsr_sig;
      frames          <= frames_sig;
      tipo_cubo       <= tipo_sig;
      cubo_valido     <= valido_sig;
      cubos_generados <= generados_sig;
    end
  end

  always_comb begin
    estado_sig    = estado;
    frames_sig    = frames;
    tipo_sig      = tipo_cubo;
    valido_sig    = cubo_valido;
    generados_sig = cubos_generados;
    if (!habilitar) begin
      // A handshake completing on the disabling edge still counts.
      if (estado == OFERTA && cubo_listo) generados_sig = generados_inc;
      estado_sig = IDLE;
      valido_sig = 1'b0;
      frames_sig = 8'd0;
    end else begin
      case (estado)
        IDLE: begin
          valido_sig = 1'b0;
          frames_sig = 8'd0;
          estado_sig = ESPERA;
        end
        ESPERA: begin
          if (tick_frame) begin
            if (frames == ULTIMO_TICK) begin
              frames_sig = 8'd0;
              estado_sig = SORTEO;
            end else begin
              frames_sig = frames + 8'd1;
            end
          end
        end
        SORTEO: begin
          // Draw 7 is rejected; the LFSR has moved on by the next attempt.
          if (lfsr[2:0] != 3'd7) begin
            tipo_sig   = lfsr[2:0];
            valido_sig = 1'b1;
            estado_sig = OFERTA;
          end
        end
        OFERTA: begin
          if (cubo_listo) begin
            valido_sig    = 1'b0;
            generados_sig = generados_inc;
            frames_sig    = 8'd0;
            estado_sig    = ESPERA;
          end
        end
        default: estado_sig = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_generador_cubos.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_generador_cubos: model-checked bench for two generador_cubos configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_generador_cubos;

  localparam int         PER  [2] = '{3, 1};
  localparam logic [7:0] SEED [2] = '{8'hA5, 8'h01};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] hab = 2'b00;
  logic [1:0] tick = 2'b00;
  logic [1:0] listo = 2'b00;
  logic [2:0] tipo [2];
  logic       valid [2];
  logic [7:0] gen [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  generador_cubos #(.PERIODO_SPAWN(3), .SEMILLA(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .habilitar(hab[0]), .tick_frame(tick[0]),
    .cubo_listo(listo[0]), .tipo_cubo(tipo[0]), .cubo_valido(valid[0]),
    .cubos_generados(gen[0])
  );

  generador_cubos #(.PERIODO_SPAWN(1), .SEMILLA(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .habilitar(hab[1]), .tick_frame(tick[1]),
    .cubo_listo(listo[1]), .tipo_cubo(tipo[1]), .cubo_valido(valid[1]),
    .cubos_generados(gen[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Transaction-level model: waiting for ticks, drawing, offering.
  logic [7:0] m_lfsr [2];
  logic       m_active [2];
  logic       m_off [2];
  logic       m_draw [2];
  int         m_ticks [2];
  int         m_typ [2];
  int         m_cnt [2];
  int         m_xfers [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_lfsr[k] <= SEED[k]; m_active[k] <= 1'b0; m_off[k] <= 1'b0;
        m_draw[k] <= 1'b0; m_ticks[k] <= 0; m_typ[k] <= 0; m_cnt[k] <= 0;
      end else begin
        m_lfsr[k] <= step(m_lfsr[k]);
        if (!hab[k]) begin
          if (m_off[k] && listo[k]) begin
            m_cnt[k] <= (m_cnt[k] == 255) ? 255 : m_cnt[k] + 1;
            m_xfers[k] <= m_xfers[k] + 1;
          end
          m_active[k] <= 1'b0; m_off[k] <= 1'b0; m_draw[k] <= 1'b0; m_ticks[k] <= 0;
        end else if (!m_active[k]) begin
          m_active[k] <= 1'b1;
        end else if (m_off[k]) begin
          if (listo[k]) begin
            m_cnt[k] <= (m_cnt[k] == 255) ? 255 : m_cnt[k] + 1;
            m_xfers[k] <= m_xfers[k] + 1;
            m_off[k] <= 1'b0;
            m_ticks[k] <= 0;
          end
        end else if (m_draw[k]) begin
          if (m_lfsr[k] % 8 != 7) begin
            m_typ[k] <= int'(m_lfsr[k] % 8);
            m_off[k] <= 1'b1;
            m_draw[k] <= 1'b0;
          end
        end else if (tick[k]) begin
          if (m_ticks[k] + 1 == PER[k]) begin
            m_draw[k] <= 1'b1;
            m_ticks[k] <= 0;
          end else begin
            m_ticks[k] <= m_ticks[k] + 1;
          end
        end
      end
    end
  end

  logic [7:0] seen [2];
  initial begin
    m_xfers[0] = 0; m_xfers[1] = 0;
    seen[0] = 8'h00; seen[1] = 8'h00;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check(k == 0 ? "a.valido" : "b.valido", int'(valid[k]), int'(m_off[k]));
      check(k == 0 ? "a.tipo" : "b.tipo", int'(tipo[k]), m_typ[k]);
      check(k == 0 ? "a.generados" : "b.generados", int'(gen[k]), m_cnt[k]);
      if (valid[k]) begin
        check(k == 0 ? "a.tipo_no_7" : "b.tipo_no_7", int'(tipo[k] != 3'd7), 1);
        seen[k][tipo[k]] = 1'b1;
      end
    end
  end

  task automatic pulse_tick(input int k);
    @(negedge clk) tick[k] = 1'b1;
    @(negedge clk) tick[k] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_valid(input int k, input string name);
    int n = 0;
    while (!valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(valid[k]), 1);
  endtask

  initial begin
    logic [2:0] held;
    int n;
    repeat (2) @(negedge clk);
    check("reset_valido", int'(valid[0]), 0);
    check("reset_generados", int'(gen[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) hab[0] = 1'b1; listo[0] = 1'b1;
    @(negedge clk);

    // Cadence: one offer every third tick, consumed at once.
    repeat (9) pulse_tick(0);
    check("cadencia_generados", int'(gen[0]), 3);

    // Backpressure: offer must hold across many ticks.
    listo[0] = 1'b0;
    repeat (3) pulse_tick(0);
    wait_valid(0, "bp_oferta");
    held = tipo[0];
    repeat (47) pulse_tick(0);
    check("bp_valido_sostenido", int'(valid[0]), 1);
    check("bp_tipo_estable", int'(tipo[0]), int'(held));
    check("bp_generados", int'(gen[0]), 3);
    @(negedge clk) listo[0] = 1'b1;
    @(negedge clk);
    check("bp_liberado_generados", int'(gen[0]), 4);
    repeat (2) pulse_tick(0);
    check("bp_sin_oferta_2ticks", int'(valid[0]), 0);
    pulse_tick(0);
    check("bp_tercer_tick_generados", int'(gen[0]), 5);

    // Enable drop on the transfer edge.
    listo[0] = 1'b0;
    repeat (3) pulse_tick(0);
    wait_valid(0, "drop_oferta");
    @(negedge clk) listo[0] = 1'b1; hab[0] = 1'b0;
    @(negedge clk);
    check("drop_generados", int'(gen[0]), 6);
    check("drop_valido", int'(valid[0]), 0);
    repeat (5) pulse_tick(0);
    check("deshab_sin_oferta", int'(valid[0]), 0);
    hab[0] = 1'b1;
    @(negedge clk);
    repeat (2) pulse_tick(0);
    check("rehab_sin_oferta_2ticks", int'(valid[0]), 0);
    pulse_tick(0);
    check("rehab_generados", int'(gen[0]), 7);

    // Asynchronous reset with an offer in flight.
    listo[0] = 1'b0;
    repeat (3) pulse_tick(0);
    wait_valid(0, "reset_oferta");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valido", int'(valid[0]), 0);
    check("async_tipo", int'(tipo[0]), 0);
    check("async_generados", int'(gen[0]), 0);
    hab = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("lfsr_a_1", int'(dut_a.lfsr), 8'h4A);
    check("lfsr_b_1", int'(dut_b.lfsr), 8'h02);
    @(negedge clk);
    check("lfsr_a_2", int'(dut_a.lfsr), 8'h95);
    check("lfsr_b_2", int'(dut_b.lfsr), 8'h04);
    @(negedge clk);
    check("lfsr_a_3", int'(dut_a.lfsr), 8'h2A);
    check("lfsr_b_3", int'(dut_b.lfsr), 8'h08);

    // Distribution and saturation with PERIODO_SPAWN=1 and zero seed.
    hab[1] = 1'b1; tick[1] = 1'b1;
    n = 0;
    while (m_xfers[1] < 2000 && n < 30000) begin
      @(negedge clk) listo[1] = 1'($urandom_range(0, 1));
      n++;
    end
    check("dist_transferencias", int'(m_xfers[1] >= 2000), 1);
    check("dist_saturado", int'(gen[1]), 255);
    for (int v = 0; v < 7; v++) check($sformatf("dist_visto_%0d", v), int'(seen[1][v]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
